// File: rtl/pooling.sv
// Lane-wise pooling stage between the matrix-multiply array and the activation stage.
// Each lane pools K consecutive valid beats (K = 1, 2 or 4) and emits one registered
// beat one cycle after the K-th beat. A gap in in_data_available ends a window early;
// the partial window is then flushed on the following cycle.
// Optional feature macro: POOL_AVG_EN enables average mode (selected by pool_select);
// without it only max pooling is built and the accumulator is DWIDTH wide.
// Handshake: in_data_available qualifies inp_data/validity_mask in the cycle it is high,
// with no backpressure; out_data_available qualifies out_data for exactly one cycle.
// The FSM state is exposed on o_dbg_state (0 = IDLE, 1 = ACCUM, 2 = FLUSH).
`ifndef MAT_MUL_SIZE
  `define MAT_MUL_SIZE 4
`endif
`ifndef DWIDTH
  `define DWIDTH 8
`endif
`ifndef MASK_WIDTH
  `define MASK_WIDTH 4
`endif

module pooling (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable_pool,
  input  logic [1:0]                        pool_window_size,
  input  logic                              pool_select,
  input  logic                              in_data_available,
  input  logic [`MAT_MUL_SIZE*`DWIDTH-1:0]  inp_data,
  input  logic [`MASK_WIDTH-1:0]            validity_mask,
  output logic [`MAT_MUL_SIZE*`DWIDTH-1:0]  out_data,
  output logic                              out_data_available,
  output logic                              done_pool,
  output logic [1:0]                        o_dbg_state
);

  localparam int LANES = `MAT_MUL_SIZE;
  localparam int DW    = `DWIDTH;
`ifdef POOL_AVG_EN
  localparam int AW    = DW + 2;
`else
  localparam int AW    = DW;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]              r_state;
  logic [1:0]              r_cnt;
  logic signed [AW-1:0]    r_acc [LANES];
  logic [`MASK_WIDTH-1:0]  r_mask;
  logic [LANES*DW-1:0]     r_out_data;
  logic                    r_out_valid;
  logic                    r_done;

  logic [1:0]              w_shift;
  logic [1:0]              w_k_last;
  logic signed [AW-1:0]    w_comb [LANES];
  logic [LANES*DW-1:0]     w_beat_res;
  logic [LANES*DW-1:0]     w_flush_res;

`ifdef POOL_AVG_EN
  logic w_avg;
  assign w_avg = pool_select;
`else
  // Max-only build: the select input has no effect.
  logic w_unused_pool_select;
  assign w_unused_pool_select = pool_select;
`endif

  // Window size decode: shift amount log2(K) and the index of the last beat.
  always_comb begin
    w_shift  = 2'd2;
    w_k_last = 2'd3;
    case (pool_window_size)
      2'd0:    begin w_shift = 2'd0; w_k_last = 2'd0; end
      2'd1:    begin w_shift = 2'd1; w_k_last = 2'd1; end
      default: begin w_shift = 2'd2; w_k_last = 2'd3; end
    endcase
  end

  // Per-lane combine of the incoming beat with the accumulator, plus the two
  // possible output beats: one for a window completing now, one for a flush.
  always_comb begin
    w_beat_res  = '0;
    w_flush_res = '0;
    for (int i = 0; i < LANES; i++) begin
      logic signed [DW-1:0] v_lane;
      logic signed [AW-1:0] v_ext;
      logic signed [AW-1:0] v_beat;
      logic signed [AW-1:0] v_flush;
      v_lane = signed'(inp_data[i*DW +: DW]);
      v_ext  = AW'(v_lane);
      if (r_cnt == 2'd0)
        w_comb[i] = v_ext;
`ifdef POOL_AVG_EN
      else if (w_avg)
        w_comb[i] = r_acc[i] + v_ext;
`endif
      else
        w_comb[i] = (v_ext > r_acc[i]) ? v_ext : r_acc[i];
      v_beat  = w_comb[i];
      v_flush = r_acc[i];
`ifdef POOL_AVG_EN
      // Sums are divided by K with an arithmetic shift (floor toward -inf);
      // missing beats of a partial window count as zero.
      if (w_avg) begin
        v_beat  = w_comb[i] >>> w_shift;
        v_flush = r_acc[i] >>> w_shift;
      end
`endif
      if (validity_mask[i]) w_beat_res[i*DW +: DW]  = v_beat[DW-1:0];
      if (r_mask[i])        w_flush_res[i*DW +: DW] = v_flush[DW-1:0];
    end
  end

  // Pooling FSM: accumulate beats, emit on the K-th beat or flush on a gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
      r_mask      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b1;
    end else if (!enable_pool) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (in_data_available) begin
            for (int i = 0; i < LANES; i++) r_acc[i] <= w_comb[i];
            r_mask  <= validity_mask;
            r_done  <= 1'b0;
            r_state <= S_ACCUM;
            if (r_cnt == w_k_last) begin
              r_out_data  <= w_beat_res;
              r_out_valid <= 1'b1;
              r_cnt       <= 2'd0;
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end else if ((r_state == S_ACCUM) && (r_cnt != 2'd0)) begin
            r_state <= S_FLUSH;
          end else begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_done  <= 1'b1;
          end
        end
        S_FLUSH: begin
          r_out_data  <= w_flush_res;
          r_out_valid <= 1'b1;
          r_state     <= S_IDLE;
          r_cnt       <= 2'd0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 2'd0;
        end
      endcase
    end
  end

  // Bypass passes the input straight through; otherwise drive the registered beat.
  always_comb begin
    out_data           = enable_pool ? r_out_data  : inp_data;
    out_data_available = enable_pool ? r_out_valid : in_data_available;
    done_pool          = enable_pool ? r_done      : 1'b1;
    o_dbg_state        = r_state;
  end

endmodule

// File: tb/tb_pooling.sv
// Directed testbench for pooling (default 4 lanes x 8 bits).
module tb_pooling;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_pool;
  logic [1:0]  pool_window_size;
  logic        pool_select;
  logic        in_data_available;
  logic [31:0] inp_data;
  logic [3:0]  validity_mask;
  logic [31:0] out_data;
  logic        out_data_available;
  logic        done_pool;
  logic [1:0]  o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  pooling dut (
    .clk                (clk),
    .reset              (reset),
    .enable_pool        (enable_pool),
    .pool_window_size   (pool_window_size),
    .pool_select        (pool_select),
    .in_data_available  (in_data_available),
    .inp_data           (inp_data),
    .validity_mask      (validity_mask),
    .out_data           (out_data),
    .out_data_available (out_data_available),
    .done_pool          (done_pool),
    .o_dbg_state        (o_dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one clock and settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d);
    in_data_available = 1'b1;
    inp_data          = d;
    step();
  endtask

  initial begin
    // Reset held two cycles with pooling enabled
    reset = 1'b1; enable_pool = 1'b1; pool_window_size = 2'd1; pool_select = 1'b0;
    in_data_available = 1'b0; inp_data = '0; validity_mask = 4'hF;
    step(); step();
    check("rst_data",  out_data, 32'h0);
    check("rst_valid", {31'b0, out_data_available}, 32'h0);
    check("rst_done",  {31'b0, done_pool}, 32'h1);
    check("rst_state", {30'b0, o_dbg_state}, 32'h0);
    reset = 1'b0;
    step();

    // K=2 max: lane0 {5,-3}, lane1 {-2,-1}, lane2 {10,3}, lane3 {0,-128}
    beat(32'h000AFE05);
    check("k2_b1_valid", {31'b0, out_data_available}, 32'h0);
    check("k2_b1_done",  {31'b0, done_pool}, 32'h0);
    beat(32'h8003FFFD);
    check("k2_valid", {31'b0, out_data_available}, 32'h1);
    check("k2_data",  out_data, 32'h000AFF05);
    check("k2_done_low", {31'b0, done_pool}, 32'h0);
    in_data_available = 1'b0;
    step();
    check("k2_pulse_end", {31'b0, out_data_available}, 32'h0);
    check("k2_done_high", {31'b0, done_pool}, 32'h1);

    // K=4 with pool_select=1, lane1 masked off
    pool_window_size = 2'd2; pool_select = 1'b1; validity_mask = 4'b1101;
    beat(32'h010407FF);
    beat(32'h020407FE);
    beat(32'h030407FD);
    check("k4_b3_valid", {31'b0, out_data_available}, 32'h0);
    beat(32'h040407FC);
    check("k4_valid", {31'b0, out_data_available}, 32'h1);
`ifdef POOL_AVG_EN
    check("k4_avg_data", out_data, 32'h020400FD);
`else
    check("k4_max_only_data", out_data, 32'h040400FF);
`endif
    in_data_available = 1'b0;
    step();
    check("k4_done", {31'b0, done_pool}, 32'h1);

    // K=1 back-to-back: each beat registered one cycle later
    pool_window_size = 2'd0; pool_select = 1'b0; validity_mask = 4'hF;
    beat(32'h11223344);
    check("k1_a_valid", {31'b0, out_data_available}, 32'h1);
    check("k1_a_data",  out_data, 32'h11223344);
    beat(32'hA5A5A5A5);
    check("k1_b_valid", {31'b0, out_data_available}, 32'h1);
    check("k1_b_data",  out_data, 32'hA5A5A5A5);
    in_data_available = 1'b0;
    step();
    check("k1_gap_valid", {31'b0, out_data_available}, 32'h0);

    // K=4 max, three beats then a gap: partial window is flushed
    pool_window_size = 2'd3;
    beat(32'h0000FB01);
    beat(32'h0000FA07);
    beat(32'h0000F902);
    in_data_available = 1'b0;
    step();
    check("fl_state", {30'b0, o_dbg_state}, 32'h2);
    check("fl_wait_valid", {31'b0, out_data_available}, 32'h0);
    step();
    check("fl_valid", {31'b0, out_data_available}, 32'h1);
    check("fl_data",  out_data, 32'h0000FB07);
    check("fl_done_low", {31'b0, done_pool}, 32'h0);
    step();
    check("fl_pulse_end", {31'b0, out_data_available}, 32'h0);
    check("fl_done_high", {31'b0, done_pool}, 32'h1);
    check("fl_idle", {30'b0, o_dbg_state}, 32'h0);

    // Bypass is combinational
    enable_pool = 1'b0; inp_data = 32'h80FF0102; in_data_available = 1'b1;
    #1;
    check("byp_data",  out_data, 32'h80FF0102);
    check("byp_valid", {31'b0, out_data_available}, 32'h1);
    check("byp_done",  {31'b0, done_pool}, 32'h1);
    in_data_available = 1'b0;
    #1;
    check("byp_valid_low", {31'b0, out_data_available}, 32'h0);
    step();

    // K=2, second beat coincides with reset: no output pulse, state cleared
    enable_pool = 1'b1; pool_window_size = 2'd1;
    step();
    beat(32'h01020304);
    reset = 1'b1;
    beat(32'h05060708);
    check("mrst_valid", {31'b0, out_data_available}, 32'h0);
    check("mrst_data",  out_data, 32'h0);
    check("mrst_state", {30'b0, o_dbg_state}, 32'h0);
    reset = 1'b0; in_data_available = 1'b0;
    step();
    check("mrst_after_valid", {31'b0, out_data_available}, 32'h0);
    check("mrst_after_done",  {31'b0, done_pool}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pooling.md
POOLING -- requirements
Module: pooling

Interface
REQ-001 Macro MAT_MUL_SIZE, default 4, lanes per data beat.
REQ-002 Macro DWIDTH, default 8, signed two's-complement lane width.
REQ-003 Macro MASK_WIDTH, default 4 (= MAT_MUL_SIZE), one validity bit per lane.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable_pool  input  1  1 = pool, 0 = bypass.
REQ-007 pool_window_size  input  2  window K: 0→1, 1→2, 2→4, 3→4.
REQ-008 pool_select  input  1  0 = max, 1 = average.
REQ-009 in_data_available  input  1  inp_data valid this cycle.
REQ-010 inp_data  input  MAT_MUL_SIZE*DWIDTH  lane i at bits [i*DWIDTH+DWIDTH-1 : i*DWIDTH].
REQ-011 validity_mask  input  MASK_WIDTH  lane i active when bit i = 1.
REQ-012 out_data  output  MAT_MUL_SIZE*DWIDTH  pooled beat, consumed by the activation stage.
REQ-013 out_data_available  output  1  out_data valid this cycle.
REQ-014 done_pool  output  1  pooling of current stream complete.

Function
REQ-015 Bypass (enable_pool=0): out_data=inp_data, out_data_available=in_data_available, done_pool=1, combinationally; internal state held in IDLE.
REQ-016 Pooling is lane-wise across K consecutive valid beats; no cross-lane combining.
REQ-017 FSM states IDLE, ACCUM, FLUSH; beat counter cnt 0..K-1; per-lane accumulator DWIDTH+2 bits signed.
REQ-018 IDLE/ACCUM with in_data_available=1: cnt=0 loads acc=sign-extended lane; cnt>0 combines (max: signed larger; avg: sum); state→ACCUM.
REQ-019 On beat where cnt=K-1: next cycle out_data registered, out_data_available=1 for exactly one cycle, cnt→0; latency 1 cycle after the K-th beat.
REQ-020 K=1: every valid beat produces output 1 cycle later (pure register stage).
REQ-021 Avg result = acc arithmetic-shifted right by log2(K) (floor toward −inf), truncated to DWIDTH; max result = acc low DWIDTH bits.
REQ-022 Lanes with validity_mask bit 0 output all-zero; mask sampled on the window's final beat.
REQ-023 ACCUM with in_data_available=0 and cnt≠0: state→FLUSH; FLUSH emits partial window next cycle (max over received beats; avg divides by K, missing beats count as zero), then IDLE, cnt→0.
REQ-024 ACCUM with in_data_available=0 and cnt=0: state→IDLE, no output.
REQ-025 done_pool (enabled): registered; 1 in IDLE when no partial window pending; 0 from first accepted beat until the cycle after the last output of the stream; 1 one cycle after that output.
REQ-026 pool_window_size, pool_select, enable_pool are required stable while state≠IDLE; changes mid-window yield unspecified data but no FSM lockup.
REQ-027 Gaps in in_data_available of one cycle end the window (REQ-023); back-to-back windows accepted every cycle with no bubble.

Reset
REQ-028 reset=1 at posedge: state=IDLE, cnt=0, acc=0, registered out_data=0, out_data_available=0, done_pool register=1.
REQ-029 Reset mid-window discards partial results; no flush output is produced.

Configuration
REQ-030 Macro POOL_AVG_EN defined: average mode available per pool_select.
REQ-031 POOL_AVG_EN undefined: pool_select ignored, max mode only; accumulator width DWIDTH; no adder/shifter instantiated.

Verification
REQ-032 Reset held 2 cycles → out_data=0, out_data_available=0, done_pool=1, with enable_pool=1.
REQ-033 K=2, max, mask=4'hF, beats lane0 {5, −3} → 1 cycle after 2nd beat out lane0=5, out_data_available one-cycle pulse.
REQ-034 K=4, avg, lane0 {−1,−2,−3,−4} → out lane0=−3 (−10>>2 floor); lane with mask bit 0 → 0.
REQ-035 K=4, max, 3 beats {1,7,2} then in_data_available=0 → FLUSH output lane0=7, then done_pool=1 next cycle.
REQ-036 enable_pool=0, inp_data=32'h80FF0102, in_data_available=1 → same cycle out_data=32'h80FF0102, out_data_available=1, done_pool=1.
REQ-037 K=2, 2 beats accepted then reset asserted before output → no out_data_available pulse, state IDLE, out_data=0.
